// File: rtl/simd_sat_au_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : au_pkg
//  Purpose  : Shared types and helpers for the saturating SIMD arithmetic
//             unit: operation encoding, flag bundle and saturation limits.
//  Ports    : n/a (package)
//  Revision : 1.0 - initial release
// ============================================================================
package au_pkg;

    typedef enum logic [1:0] {
        AU_ADD  = 2'b00,
        AU_SUB  = 2'b01,
        AU_PADD = 2'b10,
        AU_PSUB = 2'b11
    } au_op_e;

    typedef struct packed {
        logic v;
        logic n;
        logic z;
    } au_flags_t;

    // Largest positive two's-complement value of a w-bit field (0111...1),
    // returned zero-extended to 64 bits; callers cast to their width.
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit field (1000...0).
    function automatic logic [63:0] sat_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/simd_sat_au_if.sv
`default_nettype none
// ============================================================================
//  Interface : simd_sat_au_if
//  Purpose   : Operand/result handshake bundle of the saturating arithmetic
//              unit, plus the registered flag outputs.
//  Signals   : in_valid/in_ready/in_op/in_flag_en/in_a/in_b  (request side)
//              out_valid/out_ready/out_result                 (result side)
//              flag_v/flag_n/flag_z                           (flag register)
//  Modports  : master - producer/consumer around the unit
//              slave  - the unit itself
//  Revision  : 1.0 - initial release
// ============================================================================
interface simd_sat_au_if
    import au_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    au_op_e           in_op;
    logic             in_flag_en;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;

    logic             flag_v;
    logic             flag_n;
    logic             flag_z;

    modport master (
        output in_valid, in_op, in_flag_en, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, flag_v, flag_n, flag_z
    );

    modport slave (
        input  in_valid, in_op, in_flag_en, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, flag_v, flag_n, flag_z
    );

endinterface
`default_nettype wire

// File: rtl/simd_sat_au_sat_lane.sv
`default_nettype none
// ============================================================================
//  Module   : sat_lane
//  Purpose  : Combinational W-bit add/subtract segment with signed overflow
//             detection and saturation.
//  Ports    : a, b   - segment operands
//             sub    - invert b (subtract)
//             cin    - carry into the segment LSB
//             sum    - raw wrapped sum
//             cout   - carry out of the segment MSB
//             ovf    - signed overflow of this segment
//             tsign  - sign of the mathematically exact result
//             sat    - segment result after saturation
//  Revision : 1.0 - initial release
// ============================================================================
module sat_lane
    import au_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         tsign,
    output logic [W-1:0] sat
);

    localparam logic [W-1:0] LANE_MAX = W'(sat_max(W));
    localparam logic [W-1:0] LANE_MIN = W'(sat_min(W));

    logic [W-1:0] b_eff;
    logic [W:0]   total;

    always_comb begin
        b_eff = sub ? ~b : b;
        total = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
    end

    assign sum   = total[W-1:0];
    assign cout  = total[W];
    // Like-signed operands producing an opposite-signed sum cannot be exact.
    assign ovf   = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
    // On overflow the wrapped MSB is wrong; the carry out holds the true sign.
    assign tsign = ovf ? cout : sum[W-1];
    assign sat   = ovf ? (tsign ? LANE_MIN : LANE_MAX) : sum;

endmodule
`default_nettype wire

// File: rtl/simd_sat_au.sv
`default_nettype none
// ============================================================================
//  Module   : simd_sat_au
//  Purpose  : Two-stage pipelined saturating add/sub unit with full-width and
//             packed-lane modes and a registered V/N/Z flag set.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - simd_sat_au_if.slave (request, result, flags)
//  Revision : 1.0 - initial release
// ============================================================================
module simd_sat_au
    import au_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 2
) (
    input  logic          clk,
    input  logic          rst,
    simd_sat_au_if.slave  bus
);

    localparam int LANE_W = WIDTH / LANES;

    localparam logic [WIDTH-1:0] FULL_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] FULL_MIN = WIDTH'(sat_min(WIDTH));

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic             s1_valid;
    au_op_e           s1_op;
    logic             s1_flag_en;
    logic [WIDTH-1:0] s1_sum;
    logic [WIDTH-1:0] s1_sat;
    logic             s1_ovf;
    logic             s1_tsign;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    au_flags_t        s2_flags;
    logic             s2_flag_en;

    au_flags_t        flags_q;

    logic             s2_adv;
    logic             s1_adv;

    assign s2_adv = ~s2_valid | bus.out_ready;
    assign s1_adv = ~s1_valid | s2_adv;

    // ------------------------------------------------------------------
    // Stage 0: lane adders driven straight from the operands
    // ------------------------------------------------------------------
    au_op_e           op_in;
    logic             sub_in;
    logic             packed_in;
    logic [WIDTH-1:0] lane_sum;
    logic [WIDTH-1:0] lane_sat;
    logic [LANES-1:0] lane_ovf;
    logic [LANES-1:0] lane_tsign;

    assign op_in     = bus.in_op;
    assign sub_in    = (op_in == AU_SUB)  || (op_in == AU_PSUB);
    assign packed_in = (op_in == AU_PADD) || (op_in == AU_PSUB);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic cin;
        logic cout;

        if (i == 0) begin : g_first
            assign cin = sub_in;
        end else begin : g_chain
            // Packed ops restart each lane with its own carry-in; full-width
            // ops ripple the previous lane's carry so the lanes form one adder.
            assign cin = packed_in ? sub_in : g_lane[i-1].cout;
        end

        sat_lane #(
            .W (LANE_W)
        ) u_lane (
            .a     (bus.in_a[i*LANE_W +: LANE_W]),
            .b     (bus.in_b[i*LANE_W +: LANE_W]),
            .sub   (sub_in),
            .cin   (cin),
            .sum   (lane_sum[i*LANE_W +: LANE_W]),
            .cout  (cout),
            .ovf   (lane_ovf[i]),
            .tsign (lane_tsign[i]),
            .sat   (lane_sat[i*LANE_W +: LANE_W])
        );
    end

    // Lower-lane overflow/sign are already folded into each lane's saturated
    // value, and the top carry into the top lane's true sign.
    logic unused_bits;
    assign unused_bits = ^{g_lane[LANES-1].cout, lane_ovf, lane_tsign};

    // ------------------------------------------------------------------
    // Stage 1 -> 2 combinational: pick saturation scope, derive flags
    // ------------------------------------------------------------------
    logic             s1_packed;
    logic [WIDTH-1:0] res_next;
    au_flags_t        flags_next;

    always_comb begin
        s1_packed  = (s1_op == AU_PADD) || (s1_op == AU_PSUB);
        res_next   = s1_sum;
        if (s1_packed) begin
            res_next = s1_sat;
        end else if (s1_ovf) begin
            // With the chain closed the top lane sees the whole word's signs,
            // so its overflow/true sign decide saturation of the full word.
            res_next = s1_tsign ? FULL_MIN : FULL_MAX;
        end
        flags_next.v = s1_ovf;
        flags_next.n = s1_tsign;
        flags_next.z = (res_next == '0);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_op      <= AU_ADD;
            s1_flag_en <= 1'b0;
            s1_sum     <= '0;
            s1_sat     <= '0;
            s1_ovf     <= 1'b0;
            s1_tsign   <= 1'b0;
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_flags   <= '0;
            s2_flag_en <= 1'b0;
            flags_q    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op      <= op_in;
                    s1_flag_en <= bus.in_flag_en;
                    s1_sum     <= lane_sum;
                    s1_sat     <= lane_sat;
                    s1_ovf     <= lane_ovf[LANES-1];
                    s1_tsign   <= lane_tsign[LANES-1];
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result  <= res_next;
                    s2_flags   <= flags_next;
                    s2_flag_en <= s1_flag_en;
                end
            end
            if (s2_valid && bus.out_ready && s2_flag_en) begin
                flags_q <= s2_flags;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_result;
    assign bus.flag_v     = flags_q.v;
    assign bus.flag_n     = flags_q.n;
    assign bus.flag_z     = flags_q.z;

endmodule
`default_nettype wire

// File: tb/tb_simd_sat_au.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simd_sat_au
//  Purpose  : Self-checking bench for simd_sat_au (WIDTH=16, LANES=2):
//             vector table, backpressure ordering, flag hold, async reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simd_sat_au;
    import au_pkg::*;

    typedef struct {
        au_op_e      op;
        logic        fe;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  flags;   // {V, N, Z}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    simd_sat_au_if #(.WIDTH(16)) bus ();

    simd_sat_au #(
        .WIDTH (16),
        .LANES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] cur_flags();
        return {bus.flag_v, bus.flag_n, bus.flag_z};
    endfunction

    // Entered and left at posedge+1 with an empty pipeline.
    task automatic run_vec(input vec_t v);
        bus.in_valid   = 1'b1;
        bus.in_op      = v.op;
        bus.in_flag_en = v.fe;
        bus.in_a       = v.a;
        bus.in_b       = v.b;
        bus.out_ready  = 1'b1;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("out_valid_t+1", {31'd0, bus.out_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("out_valid_t+2", {31'd0, bus.out_valid}, 32'd1);
        chk("result", {16'd0, bus.out_result}, {16'd0, v.res});
        tick();
        @(negedge clk);
        chk("flags_vnz", {29'd0, cur_flags()}, {29'd0, v.flags});
        chk("out_valid_drain", {31'd0, bus.out_valid}, 32'd0);
        tick();
    endtask

    vec_t        vecs [14];
    vec_t        bp   [4];
    vec_t        post;
    logic [2:0]  model_fl;
    int          nin;
    int          nout;

    initial begin
        vecs[0]  = '{AU_ADD,  1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b100};
        vecs[1]  = '{AU_SUB,  1'b1, 16'h8000, 16'h0001, 16'h8000, 3'b110};
        vecs[2]  = '{AU_SUB,  1'b1, 16'h0005, 16'h0005, 16'h0000, 3'b001};
        vecs[3]  = '{AU_ADD,  1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b001};
        vecs[4]  = '{AU_PADD, 1'b1, 16'h7F80, 16'h0180, 16'h7F80, 3'b100};
        vecs[5]  = '{AU_PSUB, 1'b1, 16'h0100, 16'h0200, 16'hFF00, 3'b010};
        vecs[6]  = '{AU_PADD, 1'b1, 16'h00FF, 16'h0001, 16'h0000, 3'b001};
        vecs[7]  = '{AU_ADD,  1'b1, 16'h00FF, 16'h0001, 16'h0100, 3'b000};
        vecs[8]  = '{AU_PSUB, 1'b1, 16'h807F, 16'h01FF, 16'h807F, 3'b110};
        vecs[9]  = '{AU_ADD,  1'b1, 16'h8000, 16'h8000, 16'h8000, 3'b110};
        vecs[10] = '{AU_ADD,  1'b1, 16'h1234, 16'h4321, 16'h5555, 3'b000};
        vecs[11] = '{AU_SUB,  1'b1, 16'h0000, 16'h8000, 16'h7FFF, 3'b100};
        vecs[12] = '{AU_PADD, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFEFE, 3'b010};
        vecs[13] = '{AU_SUB,  1'b1, 16'h8000, 16'h7FFF, 16'h8000, 3'b110};

        bp[0] = '{AU_ADD,  1'b1, 16'h0001, 16'h0002, 16'h0003, 3'b000};
        bp[1] = '{AU_SUB,  1'b0, 16'h0010, 16'h0001, 16'h000F, 3'b000};
        bp[2] = '{AU_PADD, 1'b1, 16'h7F7F, 16'h0101, 16'h7F7F, 3'b100};
        bp[3] = '{AU_PSUB, 1'b0, 16'h0A0A, 16'h0101, 16'h0909, 3'b000};

        post  = '{AU_ADD,  1'b1, 16'h0003, 16'h0004, 16'h0007, 3'b000};

        bus.in_valid   = 1'b0;
        bus.in_op      = AU_ADD;
        bus.in_flag_en = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.out_ready  = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_result", {16'd0, bus.out_result}, 32'd0);
        chk("rst_flags", {29'd0, cur_flags()}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();

        // ---------------- vector table ----------------
        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end
        model_fl = vecs[13].flags;

        // ---------------- backpressure: X,Y,Z,W ----------------
        nin  = 0;
        nout = 0;
        for (int c = 0; c < 12; c++) begin
            bus.out_ready = (c >= 4);
            if (nin < 4) begin
                bus.in_valid   = 1'b1;
                bus.in_op      = bp[nin].op;
                bus.in_flag_en = bp[nin].fe;
                bus.in_a       = bp[nin].a;
                bus.in_b       = bp[nin].b;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            chk("bp_flags", {29'd0, cur_flags()}, {29'd0, model_fl});
            if (c < 4) begin
                chk("bp_in_ready", {31'd0, bus.in_ready}, (c < 2) ? 32'd1 : 32'd0);
            end
            if (c == 2 || c == 3) begin
                chk("bp_stall_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("bp_stall_result", {16'd0, bus.out_result}, {16'd0, bp[0].res});
            end
            if (bus.in_valid && bus.in_ready) begin
                nin++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (nout < 4) begin
                    chk("bp_order", {16'd0, bus.out_result}, {16'd0, bp[nout].res});
                    chk("bp_pop_cycle", c, 4 + nout);
                    if (bp[nout].fe) begin
                        model_fl = bp[nout].flags;
                    end
                end
                nout++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_accept_count", nin, 32'd4);
        chk("bp_pop_count", nout, 32'd4);

        // ---------------- async reset with two ops in flight ----------------
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_op      = AU_ADD;
        bus.in_flag_en = 1'b1;
        bus.in_a       = 16'h1111;
        bus.in_b       = 16'h1111;
        tick();
        bus.in_op      = AU_SUB;
        bus.in_a       = 16'h0003;
        bus.in_b       = 16'h0001;
        tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("pre_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_out_result", {16'd0, bus.out_result}, 32'd0);
        chk("mid_rst_flags", {29'd0, cur_flags()}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        run_vec(post);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
